// File: rtl/aemb2_wbldr_pkg.sv
// Shared types and byte codes for the aeMB2 byte-stream Wishbone loader.
// Holds the loader state encoding plus the command and response byte values.
package aemb2_wbldr_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        ADDR = 3'd1,
        DATA = 3'd2,
        BUS  = 3'd3,
        RESP = 3'd4
    } state_t;

    localparam logic [7:0] OP_WR   = 8'h57;
    localparam logic [7:0] OP_RD   = 8'h52;
    localparam logic [7:0] RSP_ACK = 8'h06;
    localparam logic [7:0] RSP_NAK = 8'h15;

endpackage

// File: rtl/aemb2_wbldr.sv
// Byte-stream to Wishbone loader: decodes single-word read/write frames from
// an rx byte channel, runs one classic Wishbone cycle and streams a response.
module aemb2_wbldr
    import aemb2_wbldr_pkg::*;
#(
    parameter int AW  = 14,
    parameter int TMO = 255
) (
    input  logic          sys_clk_i,
    input  logic          sys_rst_ni,
    input  logic [7:0]    rx_dat_i,
    input  logic          rx_stb_i,
    output logic          rx_rdy_o,
    output logic [7:0]    tx_dat_o,
    output logic          tx_stb_o,
    input  logic          tx_rdy_i,
    output logic [AW-3:0] mwb_adr_o,
    output logic [31:0]   mwb_dat_o,
    output logic [3:0]    mwb_sel_o,
    output logic          mwb_stb_o,
    output logic          mwb_wre_o,
    output logic          mwb_cyc_o,
    output logic          mwb_tag_o,
    input  logic [31:0]   mwb_dat_i,
    input  logic          mwb_ack_i
);

    localparam int             TW    = $clog2(TMO + 1);
    localparam logic [TW-1:0]  TMO_C = TW'(TMO);

    state_t         state_r;
    logic [1:0]     cnt_r;
    logic           is_wr_r;
    logic [23:0]    addr_sh_r;
    logic [23:0]    data_sh_r;
    logic [23:0]    resp_sh_r;
    logic [TW-1:0]  tmo_r;

    logic           rx_fire_s;
    logic           tx_fire_s;
    logic           tmo_hit_s;
    logic [31:0]    addr_nx_s;
    logic [31:0]    data_nx_s;
    logic           unused_addr_s;

    assign mwb_sel_o = 4'hF;
    assign mwb_tag_o = 1'b0;

    // Byte intake is only open while a frame is being assembled.
    assign rx_rdy_o  = sys_rst_ni & ((state_r == IDLE) | (state_r == ADDR) | (state_r == DATA));
    assign rx_fire_s = rx_stb_i & rx_rdy_o;
    assign tx_fire_s = tx_stb_o & tx_rdy_i;
    assign tmo_hit_s = (tmo_r == TMO_C);

    // The fourth byte of a field completes the word without an extra cycle.
    assign addr_nx_s = {addr_sh_r, rx_dat_i};
    assign data_nx_s = {data_sh_r, rx_dat_i};

    // Address bits above AW-1 and the byte-lane bits are discarded.
    assign unused_addr_s = &{1'b0, addr_nx_s};

    // Loader FSM with all bus and tx outputs registered.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_ni) begin
            state_r   <= IDLE;
            cnt_r     <= 2'd0;
            is_wr_r   <= 1'b0;
            addr_sh_r <= 24'h0;
            data_sh_r <= 24'h0;
            resp_sh_r <= 24'h0;
            tmo_r     <= '0;
            mwb_adr_o <= '0;
            mwb_dat_o <= 32'h0;
            mwb_stb_o <= 1'b0;
            mwb_cyc_o <= 1'b0;
            mwb_wre_o <= 1'b0;
            tx_dat_o  <= 8'h00;
            tx_stb_o  <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (rx_fire_s) begin
                        cnt_r <= 2'd0;
                        if ((rx_dat_i == OP_WR) || (rx_dat_i == OP_RD)) begin
                            is_wr_r <= (rx_dat_i == OP_WR);
                            state_r <= ADDR;
                        end else begin
                            tx_dat_o <= RSP_NAK;
                            tx_stb_o <= 1'b1;
                            state_r  <= RESP;
                        end
                    end
                end
                ADDR: begin
                    if (rx_fire_s) begin
                        addr_sh_r <= addr_nx_s[23:0];
                        cnt_r     <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            mwb_adr_o <= addr_nx_s[AW-1:2];
                            if (is_wr_r) begin
                                state_r <= DATA;
                            end else begin
                                mwb_stb_o <= 1'b1;
                                mwb_cyc_o <= 1'b1;
                                mwb_wre_o <= 1'b0;
                                tmo_r     <= '0;
                                state_r   <= BUS;
                            end
                        end
                    end
                end
                DATA: begin
                    if (rx_fire_s) begin
                        data_sh_r <= data_nx_s[23:0];
                        cnt_r     <= cnt_r + 2'd1;
                        if (cnt_r == 2'd3) begin
                            mwb_dat_o <= data_nx_s;
                            mwb_stb_o <= 1'b1;
                            mwb_cyc_o <= 1'b1;
                            mwb_wre_o <= 1'b1;
                            tmo_r     <= '0;
                            state_r   <= BUS;
                        end
                    end
                end
                BUS: begin
                    if (mwb_ack_i) begin
                        mwb_stb_o <= 1'b0;
                        mwb_cyc_o <= 1'b0;
                        mwb_wre_o <= 1'b0;
                        tx_stb_o  <= 1'b1;
                        state_r   <= RESP;
                        if (is_wr_r) begin
                            tx_dat_o <= RSP_ACK;
                            cnt_r    <= 2'd0;
                        end else begin
                            tx_dat_o  <= mwb_dat_i[31:24];
                            resp_sh_r <= mwb_dat_i[23:0];
                            cnt_r     <= 2'd3;
                        end
                    end else if (tmo_hit_s) begin
                        mwb_stb_o <= 1'b0;
                        mwb_cyc_o <= 1'b0;
                        mwb_wre_o <= 1'b0;
                        tx_dat_o  <= RSP_NAK;
                        tx_stb_o  <= 1'b1;
                        cnt_r     <= 2'd0;
                        state_r   <= RESP;
                    end else begin
                        tmo_r <= tmo_r + TW'(1);
                    end
                end
                RESP: begin
                    // cnt_r counts bytes still queued behind the one on tx_dat_o.
                    if (tx_fire_s) begin
                        if (cnt_r == 2'd0) begin
                            tx_stb_o <= 1'b0;
                            state_r  <= IDLE;
                        end else begin
                            tx_dat_o  <= resp_sh_r[23:16];
                            resp_sh_r <= {resp_sh_r[15:0], 8'h00};
                            cnt_r     <= cnt_r - 2'd1;
                        end
                    end
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/aemb2_wbldr.md
# aemb2_wbldr

Byte-stream-to-Wishbone loader: the bus initiator that drives the data-memory port of the aeMB2 on-chip RAM from an external byte channel (UART or debug FIFO). It is used to load and inspect program memory while the CPU is held in reset. It decodes single-word read and write commands, issues one classic Wishbone single cycle per command, and returns a response byte stream.

## Interface
- `AW`, 14: byte-address width; the bus address is `[AW-1:2]`.
- `TMO`, 255: maximum cycles to wait for `mwb_ack_i` before aborting; range 1..65535.

- `sys_clk_i` in 1: single clock; all logic is on the rising edge.
- `sys_rst_ni` in 1: reset, synchronous, active-low.
- `rx_dat_i` in 8: command byte.
- `rx_stb_i` in 1: command byte valid.
- `rx_rdy_o` out 1: loader accepts a byte; a transfer occurs when `rx_stb_i & rx_rdy_o`.
- `tx_dat_o` out 8: response byte.
- `tx_stb_o` out 1: response byte valid.
- `tx_rdy_i` in 1: sink accepts a byte; a transfer occurs when `tx_stb_o & tx_rdy_i`.
- `mwb_adr_o` out AW-2: word address.
- `mwb_dat_o` out 32: write data.
- `mwb_sel_o` out 4: constant `4'hF`.
- `mwb_stb_o` out 1: strobe.
- `mwb_wre_o` out 1: write enable.
- `mwb_cyc_o` out 1: cycle; equals `mwb_stb_o`.
- `mwb_tag_o` out 1: constant 0.
- `mwb_dat_i` in 32: read data.
- `mwb_ack_i` in 1: responder acknowledge.

## Operation
- **Command frame.** One opcode byte, then 4 address bytes MSB first, then 4 data bytes MSB first (write only).
  - Opcodes: `0x57` is write, `0x52` is read.
  - Address bits above AW-1 and bits [1:0] are ignored.
- **FSM states.**
  - IDLE: on an opcode byte, W or R goes to ADDR with byte count 0. Any other byte goes to RESP with NAK `0x15`.
  - ADDR: after 4 bytes, W goes to DATA and R goes to BUS.
  - DATA: after 4 bytes, goes to BUS.
  - BUS: `mwb_stb_o`, `mwb_cyc_o` and `mwb_wre_o` (write only) are high.
    - On `mwb_ack_i`: strobe drops at that same edge.
    - Read: `mwb_dat_i` is captured at that edge, then RESP with 4 bytes MSB first.
    - Write: RESP with ACK `0x06`.
    - On timeout: strobe drops and RESP sends NAK.
  - RESP: holds each byte until `tx_rdy_i`, then returns to IDLE after the last byte.
- `rx_rdy_o` is 1 only in IDLE, ADDR and DATA, and is forced to 0 while `sys_rst_ni` is low. Bytes offered in BUS or RESP are not consumed.
- **Timeout counter.**
  - Width is `$clog2(TMO+1)`.
  - Clears on entering BUS.
  - Increments each BUS cycle without ack.
  - Abort fires when the count equals TMO without ack, i.e. strobe is high for at most TMO+1 cycles.
  - `mwb_ack_i` outside BUS is ignored; a late ack has no effect.
- `mwb_adr_o` and `mwb_dat_o` are stable for the whole BUS state. `tx_dat_o` is stable while `tx_stb_o` is high.
- **Reset.** Any state returns to IDLE at the reset edge. A cycle in progress is dropped without waiting for ack, and partial frames are discarded.
- **Reset values.** All registered outputs are 0: `mwb_stb_o`, `mwb_cyc_o`, `mwb_wre_o`, `mwb_adr_o`, `mwb_dat_o`, `tx_stb_o`, `tx_dat_o`. Constant outputs hold their fixed values.

## Timing
- Every bus and tx output is registered.
- The last frame byte accepted at edge N gives `mwb_stb_o` = 1 in cycle N+1.
- Against a one-cycle responder (`ack <= stb & !ack`):
  - ack is high in cycle N+2.
  - strobe is 0 and `tx_stb_o` = 1 in cycle N+3.
- Read response bytes can leave on consecutive cycles when `tx_rdy_i` is held high.
- First `rx_rdy_o` after RESP completes: the cycle after the last tx transfer.
- Minimum write command with an always-ready sink: 9 rx cycles, then 3 cycles to the response.

## Structure
- Package `aemb2_wbldr_pkg` holds:
  - the state enum (IDLE, ADDR, DATA, BUS, RESP);
  - opcode constants `OP_WR` = `8'h57` and `OP_RD` = `8'h52`;
  - response constants `RSP_ACK` = `8'h06` and `RSP_NAK` = `8'h15`.
- Single module with no sub-module. The shift registers for address, data and response and the 2-bit byte counter live in it.

## Test plan
- **Write.** Send `57 00 00 01 04 DE AD BE EF` into the RAM model (AW=14). Required: one cycle with `mwb_adr_o` = `12'h041`, `mwb_dat_o` = `32'hDEADBEEF`, `mwb_wre_o` = 1, then tx `06`.
- **Read back.** Send `52 00 00 01 04`. Required: one bus cycle with `mwb_wre_o` = 0, then tx `DE AD BE EF` in order.
- **Backpressure.** During a read response, toggle `tx_rdy_i` 1/0. Required: each byte is held stable until accepted, there are no duplicates, and `rx_rdy_o` = 0 until the fourth byte transfers.
- **Bad opcode.** Send `41`. Required: tx `15` and no `mwb_stb_o`. A subsequent valid command then completes normally.
- **Timeout.** Use TMO=8 with a responder that never acks. Required: `mwb_stb_o` high for exactly 9 cycles, then tx `15`. An ack injected 2 cycles later is ignored.
- **Reset mid-operation.** Pull `sys_rst_ni` low during BUS and during the 2nd address byte. Required: all outputs are 0 at the next edge, and the full write test passes afterwards.
